// File: rtl/ahblite_multi_timer_if.sv
// AHB-Lite bus bundle for the multi-channel timer slave.
interface ahblite_multi_timer_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE,
    output HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE,
    input  HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_multi_timer.sv
// AHB-Lite slave with NUM_CH down-counting timers sharing one prescaler.
module ahblite_multi_timer #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 RSTn,
  ahblite_multi_timer_if.slave ahb,
  output logic [NUM_CH-1:0]    IRQ
);
  logic       a_valid;
  logic       a_write;
  logic [6:0] a_addr;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
    end else begin
      a_valid <= ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
      a_write <= ahb.HWRITE;
      a_addr  <= ahb.HADDR[8:2];
    end
  end

  logic       wr, rd, presc_hit;
  logic [3:0] ch;
  logic [1:0] off;

  assign wr        = a_valid & a_write;
  assign rd        = a_valid & ~a_write;
  assign presc_hit = a_addr == 7'h40;
  assign ch        = a_addr[5:2];
  assign off       = a_addr[1:0];

  logic [PRESC_WIDTH-1:0] presc_q, pcnt_q;
  logic                   tick;

  assign tick = pcnt_q == presc_q;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (wr && presc_hit) begin
      presc_q <= ahb.HWDATA[PRESC_WIDTH-1:0];
      pcnt_q  <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PRESC_WIDTH'(1);
    end
  end

  logic [NUM_CH-1:0]                en_q, mode_q, ie_q, if_q;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] load_q, value_q;
  logic [NUM_CH-1:0]                wr_ctrl, wr_load, wr_stat;
  logic [NUM_CH-1:0]                expire;
  logic [CNT_WIDTH-1:0]             wdata_cnt;

  assign wdata_cnt = ahb.HWDATA[CNT_WIDTH-1:0];

  always_comb begin
    wr_ctrl = '0;
    wr_load = '0;
    wr_stat = '0;
    expire  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && !a_addr[6] && ch == 4'(c)) begin
        unique case (1'b1)
          off == 2'd0: wr_ctrl[c] = 1'b1;
          off == 2'd1: wr_load[c] = 1'b1;
          off == 2'd3: wr_stat[c] = 1'b1;
          default: ;
        endcase
      end
      expire[c] = tick & en_q[c] & (value_q[c] == '0);
    end
  end

  // Software writes come last so they override the tick update.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      en_q    <= '0;
      mode_q  <= '0;
      ie_q    <= '0;
      if_q    <= '0;
      load_q  <= '0;
      value_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick && en_q[c]) begin
          if (!expire[c]) begin
            value_q[c] <= value_q[c] - CNT_WIDTH'(1);
          end else begin
            if_q[c] <= 1'b1;
            if (mode_q[c]) value_q[c] <= load_q[c];
            else           en_q[c]    <= 1'b0;
          end
        end
        if (wr_ctrl[c]) begin
          en_q[c]   <= ahb.HWDATA[0];
          mode_q[c] <= ahb.HWDATA[1];
          ie_q[c]   <= ahb.HWDATA[2];
          if (ahb.HWDATA[0] && !en_q[c]) value_q[c] <= load_q[c];
        end
        if (wr_load[c]) begin
          load_q[c] <= wdata_cnt;
          if (!en_q[c]) value_q[c] <= wdata_cnt;
        end
        if (wr_stat[c] && ahb.HWDATA[0] && !expire[c]) if_q[c] <= 1'b0;
      end
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (rd && presc_hit) begin
      rdata = 32'(presc_q);
    end else if (rd && !a_addr[6]) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch == 4'(c)) begin
          case (off)
            2'd0:    rdata = 32'({ie_q[c], mode_q[c], en_q[c]});
            2'd1:    rdata = 32'(load_q[c]);
            2'd2:    rdata = 32'(value_q[c]);
            default: rdata = 32'(if_q[c]);
          endcase
        end
      end
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign IRQ           = if_q & ie_q;

  logic unused;
  assign unused = ^{ahb.HADDR[31:9], ahb.HADDR[1:0],
                    ahb.HTRANS[0], ahb.HSIZE, ahb.HPROT};
endmodule

// File: tb/tb_ahblite_multi_timer.sv
// Bench for ahblite_multi_timer: register table, timing corner cases
// and randomized channel setups checked against an arithmetic model.
module tb_ahblite_multi_timer;
  localparam int NCH = 4;

  typedef struct {
    logic        vld;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           RSTn = 1'b0;
  logic [NCH-1:0] irq;
  int cyc = 0, nvec = 0, nerr = 0, resp_bad = 0;

  ahblite_multi_timer_if bus ();

  ahblite_multi_timer #(
    .NUM_CH(NCH), .CNT_WIDTH(32), .PRESC_WIDTH(16)
  ) dut (
    .clk(clk), .RSTn(RSTn), .ahb(bus), .IRQ(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.HRESP !== 1'b0 || bus.HREADYOUT !== 1'b1)
      resp_bad <= resp_bad + 1;

  op_t            opq[$];
  op_t            done[$];
  logic [31:0]    rdq[$];
  logic [NCH-1:0] irqq[$];
  int             edq[$];
  vec_t           tbl[$];

  // Random-test model state
  int P, Ep;
  int L[NCH], M[NCH], I[NCH], E[NCH], Ee[NCH], cidx[NCH];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic q_wr(logic [31:0] a, logic [31:0] d);
    opq.push_back('{1'b1, 1'b1, a, d});
  endtask

  task automatic q_rd(logic [31:0] a);
    opq.push_back('{1'b1, 1'b0, a, 32'h0});
  endtask

  task automatic q_idle();
    opq.push_back('{1'b0, 1'b0, 32'h0, 32'h0});
  endtask

  task automatic bus_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HADDR = '0; bus.HWDATA = '0;
    bus.HSIZE = 3'b010; bus.HPROT = 4'b0011; bus.HREADY = 1'b1;
  endtask

  // Issues queued ops back to back; sample i is the data phase of op i,
  // edq[i] is the edge whose resulting state that sample shows.
  task automatic run_ops();
    int n;
    n = opq.size();
    rdq.delete(); irqq.delete(); edq.delete();
    for (int i = 0; i <= n; i++) begin
      if (i < n && opq[i].vld) begin
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10;
        bus.HWRITE = opq[i].wr; bus.HADDR = opq[i].addr;
      end else begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      end
      if (i > 0) bus.HWDATA = opq[i-1].data;
      @(negedge clk);
      if (i > 0) begin
        rdq.push_back(bus.HRDATA);
        irqq.push_back(irq);
        edq.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    done = opq;
    opq.delete();
  endtask

  task automatic do_reset();
    bus_idle();
    opq.delete();
    RSTn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) RSTn = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] model_reg(int c, int off, int s);
    int k, val, ifl, en;
    if (c >= NCH) return 32'h0;
    if (E[c] == 0) begin
      en = 0; val = L[c]; ifl = 0;
    end else begin
      k   = (s - Ep) / (P + 1) - (Ee[c] - Ep) / (P + 1);
      ifl = (k > L[c]) ? 1 : 0;
      if (M[c] != 0) begin
        en = 1; val = L[c] - k % (L[c] + 1);
      end else begin
        en = (k > L[c]) ? 0 : 1;
        val = (k >= L[c]) ? 0 : L[c] - k;
      end
    end
    case (off)
      0:       return 32'(I[c] * 4 + M[c] * 2 + en);
      1:       return 32'(L[c]);
      2:       return 32'(val);
      default: return 32'(ifl);
    endcase
  endfunction

  task automatic tv(logic w, logic [31:0] a, logic [31:0] d, logic [31:0] e);
    tbl.push_back('{w, a, d, e});
  endtask

  initial begin
    int e26[5];
    int r0, sel, bad, k, e30;
    logic [31:0]    a, ex;
    logic [NCH-1:0] ei;

    tv(0, 32'h000, 0, 0);
    tv(0, 32'h004, 0, 0);
    tv(0, 32'h008, 0, 0);
    tv(0, 32'h00C, 0, 0);
    tv(0, 32'h100, 0, 0);
    tv(1, 32'h014, 32'hDEADBEEF, 0);
    tv(0, 32'h014, 0, 32'hDEADBEEF);
    tv(0, 32'h018, 0, 32'hDEADBEEF);
    tv(1, 32'h018, 32'h5, 0);
    tv(0, 32'h018, 0, 32'hDEADBEEF);
    tv(1, 32'h010, 32'hFFFFFFFA, 0);
    tv(0, 32'h010, 0, 32'h2);
    tv(1, 32'(NCH * 16), 32'h7, 0);
    tv(0, 32'(NCH * 16), 0, 0);
    tv(1, 32'h104, 32'hFFFFFFFF, 0);
    tv(0, 32'h104, 0, 0);
    tv(1, 32'h100, 32'h00012345, 0);
    tv(0, 32'h100, 0, 32'h2345);
    tv(1, 32'h03C, 32'h1, 0);
    tv(0, 32'h03C, 0, 0);
    tv(0, 32'h01C, 0, 0);
    tv(1, 32'h030, 32'h4, 0);
    tv(0, 32'h030, 0, 32'h4);
    tv(0, 32'h1FC, 0, 0);
    tv(0, 32'h000, 0, 0);
    tv(0, 32'h014, 0, 32'hDEADBEEF);

    do_reset();
    @(negedge clk);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_hrdata", bus.HRDATA, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].wr) q_wr(tbl[i].addr, tbl[i].data);
      else           q_rd(tbl[i].addr);
    end
    run_ops();
    foreach (tbl[i])
      if (!tbl[i].wr) chk($sformatf("tbl[%0d]", i), rdq[i], tbl[i].exp);

    // Periodic ch0, LOAD=3, tick every cycle
    do_reset();
    q_wr(32'h100, 0); q_wr(32'h004, 3); q_wr(32'h000, 7);
    repeat (5) q_rd(32'h008);
    q_rd(32'h00C);
    run_ops();
    e26 = '{3, 2, 1, 0, 3};
    for (int i = 0; i < 5; i++) begin
      chk("r026_value", rdq[3+i], 32'(e26[i]));
      chk("r026_irq", 32'(irqq[3+i][0]), (i == 4) ? 32'h1 : 32'h0);
    end
    chk("r026_if", rdq[8], 1);

    // One-shot ch1 with PRESC=4
    do_reset();
    q_wr(32'h100, 4); q_wr(32'h014, 2); q_wr(32'h010, 5);
    repeat (16) q_rd(32'h01C);
    run_ops();
    chk("r027_if_early", rdq[15], 0);
    chk("r027_if_15clk", rdq[16], 1);
    chk("r027_irq", 32'(irqq[16][1]), 1);
    q_rd(32'h010); q_rd(32'h018); q_wr(32'h01C, 1);
    repeat (30) q_rd(32'h01C);
    run_ops();
    chk("r027_ctrl", rdq[0], 32'h4);
    chk("r027_value", rdq[1], 0);
    bad = 0;
    for (int i = 3; i < 33; i++) if (rdq[i] !== 32'h0) bad++;
    chk("r027_no_if", 32'(bad), 0);
    chk("r027_irq_off", 32'(irqq[32][1]), 0);

    // Periodic LOAD=0 on ch2, W1C against a tick
    do_reset();
    q_wr(32'h100, 0); q_wr(32'h024, 0); q_wr(32'h020, 7);
    q_rd(32'h02C); q_rd(32'h02C); q_wr(32'h02C, 1);
    q_rd(32'h02C); q_rd(32'h028);
    run_ops();
    chk("r028_if_enable", rdq[3], 0);
    chk("r028_if_tick", rdq[4], 1);
    chk("r028_set_wins", rdq[6], 1);
    chk("r028_value", rdq[7], 0);
    chk("r028_irq", 32'(irqq[6][2]), 1);

    // LOAD rewrite while running
    do_reset();
    q_wr(32'h100, 0); q_wr(32'h004, 10); q_wr(32'h000, 3);
    q_rd(32'h008); q_wr(32'h004, 5);
    repeat (11) q_rd(32'h008);
    q_rd(32'h004);
    run_ops();
    for (int m = 3; m < 16; m++) begin
      if (m == 4) continue;
      k = m - 3;
      e30 = (k <= 10) ? 10 - k : 5 - (k - 11);
      chk("r030_value", rdq[m], 32'(e30));
    end
    chk("r030_load", rdq[16], 5);

    // Reset in the middle of a count
    do_reset();
    q_wr(32'h100, 0); q_wr(32'h004, 21); q_wr(32'h000, 7);
    repeat (14) q_rd(32'h008);
    run_ops();
    chk("r031_pre", rdq[16], 8);
    RSTn = 1'b0;
    #2;
    chk("r031_rst_irq", 32'(irq), 0);
    chk("r031_rst_hrdata", bus.HRDATA, 0);
    @(negedge clk) RSTn = 1'b1;
    @(posedge clk); #1;
    q_rd(32'h000); q_rd(32'h004); q_rd(32'h008);
    q_rd(32'h00C); q_rd(32'h100);
    run_ops();
    for (int i = 0; i < 5; i++) chk("r031_regs", rdq[i], 0);
    bad = 0;
    repeat (100) @(negedge clk) if (irq !== '0) bad++;
    chk("r031_quiet", 32'(bad), 0);
    @(posedge clk); #1;

    // Randomized channel setups
    for (int t = 0; t < 16; t++) begin
      do_reset();
      P = $urandom_range(0, 3);
      q_wr(32'h100, 32'(P));
      for (int c = 0; c < NCH; c++) begin
        L[c] = $urandom_range(0, 12);
        M[c] = $urandom_range(0, 1);
        I[c] = $urandom_range(0, 1);
        E[c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        q_wr(32'(c * 16 + 4), 32'(L[c]));
        q_wr(32'(c * 16), 32'(I[c] * 4 + M[c] * 2 + E[c]));
        cidx[c] = opq.size() - 1;
      end
      r0 = opq.size();
      for (int j = 0; j < 40; j++) begin
        sel = $urandom_range(0, 9);
        if (sel < 2)       q_idle();
        else if (sel == 2) q_rd(32'h100);
        else q_rd(32'($urandom_range(0, NCH) * 16 + $urandom_range(0, 3) * 4));
      end
      run_ops();
      Ep = edq[0] + 1;
      for (int c = 0; c < NCH; c++) Ee[c] = edq[cidx[c]] + 1;
      for (int j = r0; j < done.size(); j++) begin
        if (!done[j].vld) continue;
        a = done[j].addr;
        if (a == 32'h100) ex = 32'(P);
        else ex = model_reg(int'(a[7:4]), int'(a[3:2]), edq[j]);
        chk("rnd_read", rdq[j], ex);
        ei = '0;
        for (int c = 0; c < NCH; c++)
          if (model_reg(c, 3, edq[j]) != 0 && I[c] != 0) ei[c] = 1'b1;
        chk("rnd_irq", 32'(irqq[j]), 32'(ei));
      end
    end

    chk("hresp_hreadyout", 32'(resp_bad), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ahblite_multi_timer.md
AHBLITE_MULTI_TIMER -- requirements
Module: ahblite_multi_timer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent timer channels (legal range 1..16).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32, giving the width of the LOAD and VALUE registers (legal range 8..32).
REQ-003 The block SHALL have parameter PRESC_WIDTH, default 16, giving the width of the shared prescaler.
REQ-004 The block SHALL use reset RSTn, asynchronous, active-low, and clock clk.
REQ-005 Ports SHALL be, one per line:
clk  in  1  system/AHB clock
RSTn  in  1  async active-low reset
HSEL  in  1  slave select
HADDR  in  32  address (bits 8:2 decoded)
HTRANS  in  2  transfer type
HSIZE  in  3  transfer size (ignored; word access only)
HPROT  in  4  protection (ignored)
HWRITE  in  1  write strobe
HWDATA  in  32  write data
HREADY  in  1  bus ready in
HREADYOUT  out  1  slave ready, tied 1
HRESP  out  1  response, tied 0 (OKAY)
HRDATA  out  32  read data
IRQ  out  NUM_CH  per-channel interrupt

Function
REQ-006 Address phase SHALL be accepted when HSEL & HREADY & HTRANS[1]; HADDR[8:2] and HWRITE are registered for the data phase.
REQ-007 A write SHALL update the addressed register at the clk edge ending its data phase, using HWDATA; zero wait states.
REQ-008 HRDATA SHALL be driven in the data phase from the registered address, reflecting register contents at that cycle; unused bits read 0.
REQ-009 Map: channel c at offset c*0x10 (HADDR[8]=0, HADDR[7:4]=c): 0x0 CTRL, 0x4 LOAD, 0x8 VALUE (read-only), 0xC STATUS; 0x100 PRESC.
REQ-010 CTRL bits: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IE; other bits read 0.
REQ-011 STATUS bit [0] IF; writing 1 clears it, writing 0 has no effect.
REQ-012 Accesses to channel index >= NUM_CH or to undefined offsets SHALL read 0; writes to them SHALL be ignored.
REQ-013 The prescaler counter SHALL count 0..PRESC and assert a one-cycle tick when equal to PRESC, then wrap to 0; PRESC=0 gives a tick every cycle.
REQ-014 Writing PRESC SHALL reset the prescaler counter to 0 in the same edge.
REQ-015 Writing CTRL with EN going 0->1 SHALL load VALUE from LOAD; counting starts on the next tick.
REQ-016 Writing LOAD while EN=0 SHALL also load VALUE; while EN=1 it affects only the next reload.
REQ-017 On a tick with EN=1 and VALUE!=0, VALUE SHALL decrement by 1.
REQ-018 On a tick with EN=1 and VALUE==0: IF set; periodic -> VALUE<=LOAD; one-shot -> EN cleared, VALUE stays 0.
REQ-019 LOAD=0 in periodic mode SHALL set IF on every tick.
REQ-020 Hardware IF set and software W1C in the same cycle: set SHALL win.
REQ-021 Software EN write and a one-shot expiry in the same cycle: software write SHALL win.
REQ-022 IRQ[c] SHALL equal IF[c] & IE[c], combinational from registers.
REQ-023 Values wider than CNT_WIDTH SHALL be truncated on write and zero-extended on read.

Reset
REQ-024 On RSTn low: CTRL, LOAD, VALUE, IF, PRESC, prescaler counter and registered address phase SHALL be 0; IRQ=0; HRDATA=0; HREADYOUT=1; HRESP=0.
REQ-025 Reset asserted mid-count SHALL abort immediately; no IF or IRQ after release until reconfigured.

Verification
REQ-026 PRESC=0, ch0 LOAD=3, CTRL=0x7 -> VALUE reads 3,2,1,0; IF=1 and IRQ[0]=1 on the 4th tick after enable; VALUE reloads to 3.
REQ-027 PRESC=4, ch1 LOAD=2, CTRL=0x5 (one-shot) -> IF set after 15 clk; EN reads 0, VALUE stays 0, no further IF after W1C.
REQ-028 Ch2 periodic LOAD=0, IE=1 -> IF every cycle; W1C of STATUS coinciding with a tick leaves IF=1.
REQ-029 Read 0x0 of channel NUM_CH and offset 0x104 -> 0; writes there change no register; HRESP stays 0.
REQ-030 Ch0 running with LOAD=10; write LOAD=5 -> current period completes from 10, next reload uses 5.
REQ-031 Assert RSTn low while ch0 at VALUE=7 -> all registers 0, IRQ=0; after release no IRQ for 100 clk.
